mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle sequencer for the processor datapath: it steps each instruction through fetch, decode, execute, memory and write-back. It holds the instruction- and data-memory request/acknowledge handshakes and drives the datapath select lines, including the immediate-extension mode for the shared sign/zero extender. It sits beside the register file, ALU and extender and replaces single-cycle control with state-sequenced strobes.

## Interface
- TIMEOUT, 255: maximum wait cycles for a memory acknowledge (only used with the timeout feature).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction fetch complete; `instr` is valid in the same cycle.
- instr  in  32  fetched instruction word.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (1 = store, 0 = load).
- dmem_ack  in  1  data access complete.
- alu_zero  in  1  ALU zero flag.
- ir_write  out  1  IR load strobe.
- pc_write  out  1  PC load strobe.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- alu_src  out  1  ALU B source: 0 = register, 1 = extended immediate.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct field, 11 = logic per opcode.
- ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source: 1 = memory, 0 = ALU.
- reg_write  out  1  register file write strobe.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- fault  out  1  sticky timeout fault.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- Reset enters IDLE. After reset is released, IDLE moves to FETCH unconditionally on the next edge.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_write = 1, pc_write = 1, pc_src = 00, and the opcode (instr[31:26]) is latched internally. Next state is DECODE.
- DECODE: one cycle.
  - Supported opcodes: R-type 000000, addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
  - Any other opcode: illegal pulses and the next state is FETCH.
- EXEC: one cycle.
  - R-type: alu_op = 10.
  - addi, lw, sw: alu_src = 1, alu_op = 00.
  - andi, ori: alu_src = 1, alu_op = 11.
  - beq: alu_op = 01; pc_write = alu_zero, pc_src = 01.
  - j: pc_write = 1, pc_src = 10.
  - Next state: lw or sw go to MEM; beq or j go to FETCH; all others go to WB.
- MEM: dmem_req = 1 and dmem_we = (opcode is sw) until dmem_ack. On ack, lw goes to WB and sw goes to FETCH.
- WB: reg_write = 1 for one cycle.
  - reg_dst = 1 only for R-type.
  - mem_to_reg = 1 only for lw.
  - Next state is FETCH.
- ext_zero = latched opcode[3] & opcode[2] (instruction bits 29 and 28), in every state from DECODE onward. This gives 1 for andi and ori and 0 otherwise.
- alu_src and alu_op hold their EXEC values through MEM and WB so the ALU result stays stable.

## Timing
- Reset values: every output is 0 and the state is IDLE. An asynchronous reset assertion in any state, including mid-handshake, drops imem_req and dmem_req immediately.
- Registered outputs: the state and the latched opcode. All strobes are decoded combinationally from the state, the opcode and the ack inputs.
- Minimum cycles per instruction, with zero-wait acks:
  - beq, j: 3.
  - R-type, immediate ops: 4.
  - sw: 4.
  - lw: 5.
- A request, once raised, is held until its ack. An ack that arrives while no request is raised is ignored.
- Only one memory request is outstanding at a time. imem_req and dmem_req are never high together.

## Configuration
- MC_CTRL_TIMEOUT_EN defined:
  - A wait counter resets on entry to FETCH or MEM and increments each cycle the ack is low.
  - When the counter reaches TIMEOUT with the ack still low, the next state is FAULT.
  - FAULT holds every strobe at 0, sets fault = 1, and is left only by reset.
- MC_CTRL_TIMEOUT_EN undefined: no counter is built, the controller waits indefinitely, and fault is tied to 0.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - the opcode constants;
  - the pc_src and alu_op encodings.
- Sub-module mc_ctrl_decode: a combinational opcode classifier. Outputs: is_rtype, is_imm, is_logic, is_load, is_store, is_branch, is_jump, illegal.

## Test plan
- addi (opcode 001000), zero-wait acks: ir_write/pc_write in cycle 1; EXEC with alu_src = 1, alu_op = 00, ext_zero = 0; reg_write in cycle 4.
- ori (001101): ext_zero = 1 from DECODE through WB; alu_op = 11 in EXEC.
- lw with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles, dmem_we = 0; then WB with mem_to_reg = 1. sw: dmem_we = 1, no reg_write.
- beq with alu_zero = 1: pc_write with pc_src = 01 in EXEC. With alu_zero = 0: no pc_write; next state FETCH.
- Opcode 111111: illegal pulses in DECODE; the next fetch starts on the following cycle.
- With MC_CTRL_TIMEOUT_EN defined and TIMEOUT = 4, imem_ack held low: fault rises after 4 wait cycles and stays high. Reset asserted mid-FETCH: imem_req drops immediately, and FETCH resumes one cycle after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle sequencer
//            (state enum, opcodes, PC-source and ALU-op select codes).
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [1:0] c_pc_plus4  = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;
    localparam logic [1:0] c_alu_logic = 2'b11;

    // Zero-extension is selected by opcode bits 3 and 2 (andi/ori family).
    function automatic logic ext_zero_mode(input logic [5:0] op);
        return op[3] & op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_decode
// Purpose  : Combinational opcode classifier for the multi-cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_imm,
    output logic       is_logic,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       illegal
);

    always_comb begin
        is_rtype  = 1'b0;
        is_imm    = 1'b0;
        is_logic  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            c_op_rtype: is_rtype = 1'b1;
            c_op_addi:  is_imm   = 1'b1;
            c_op_andi,
            c_op_ori: begin
                is_imm   = 1'b1;
                is_logic = 1'b1;
            end
            c_op_lw:    is_load   = 1'b1;
            c_op_sw:    is_store  = 1'b1;
            c_op_beq:   is_branch = 1'b1;
            c_op_j:     is_jump   = 1'b1;
            default:    illegal   = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
//            handshakes and datapath selects. Define MC_CTRL_TIMEOUT_EN to
//            build the acknowledge-timeout watchdog and sticky FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        ext_zero,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        illegal,
    output logic        fault
);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_opcode;
    logic       w_timeout;

    logic w_is_rtype, w_is_imm, w_is_logic, w_is_load;
    logic w_is_store, w_is_branch, w_is_jump, w_illegal;

    // Only the opcode field steers control; the rest belongs to the datapath.
    logic w_unused_instr;
    assign w_unused_instr = ^instr[25:0];

    mc_ctrl_decode u_decode (
        .opcode    (r_opcode),
        .is_rtype  (w_is_rtype),
        .is_imm    (w_is_imm),
        .is_logic  (w_is_logic),
        .is_load   (w_is_load),
        .is_store  (w_is_store),
        .is_branch (w_is_branch),
        .is_jump   (w_is_jump),
        .illegal   (w_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_FETCH && imem_ack) begin
                r_opcode <= instr[31:26];
            end
        end
    end

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int unsigned         c_wait_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);

    logic [c_wait_w-1:0] r_wait;

    // Restarts whenever a wait state is entered; otherwise counts ack-low cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if ((r_state != ST_FETCH && r_state != ST_MEM) ||
                     (w_state_next != r_state)) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + c_wait_one;
        end
    end

    assign w_timeout = (r_wait == c_wait_last);
    assign fault     = (r_state == ST_FAULT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout        = 1'b0;
    assign fault            = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = c_pc_plus4;
        alu_src      = 1'b0;
        alu_op       = c_alu_add;
        ext_zero     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        illegal      = 1'b0;

        if (r_state == ST_DECODE || r_state == ST_EXEC ||
            r_state == ST_MEM    || r_state == ST_WB) begin
            ext_zero = ext_zero_mode(r_opcode);
        end

        // ALU selects stay put after EXEC so the result is stable for MEM/WB.
        if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
            alu_src = w_is_imm | w_is_load | w_is_store;
            if (w_is_rtype) begin
                alu_op = c_alu_funct;
            end else if (w_is_logic) begin
                alu_op = c_alu_logic;
            end else if (w_is_branch) begin
                alu_op = c_alu_sub;
            end
        end

        case (r_state)
            ST_IDLE: w_state_next = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    illegal      = 1'b1;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_branch) begin
                    pc_write = alu_zero;
                    pc_src   = c_pc_branch;
                end
                if (w_is_jump) begin
                    pc_write = 1'b1;
                    pc_src   = c_pc_jump;
                end
                if (w_is_load || w_is_store) begin
                    w_state_next = ST_MEM;
                end else if (w_is_branch || w_is_jump) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ack) begin
                    w_state_next = w_is_load ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write    = 1'b1;
                reg_dst      = w_is_rtype;
                mem_to_reg   = w_is_load;
                w_state_next = ST_FETCH;
            end
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Self-checking bench for mc_control: per-instruction cycle scripts
//            from the instruction-level rules, randomized acks and opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int unsigned c_timeout = 4;
`else
    localparam int unsigned c_timeout = 255;
`endif

    localparam int K_R = 0, K_ADDI = 1, K_ANDI = 2, K_ORI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_J = 7, K_BAD = 8;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_zero;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
        logic       fault;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] instr;
    logic        dmem_req, dmem_we, dmem_ack, alu_zero;
    logic        ir_write, pc_write, alu_src, ext_zero;
    logic [1:0]  pc_src, alu_op;
    logic        reg_dst, mem_to_reg, reg_write, illegal, fault;
    outs_t       obs;

    int n_total = 0;
    int n_bad   = 0;

    mc_control #(.TIMEOUT(c_timeout)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr      (instr),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .alu_zero   (alu_zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .ext_zero   (ext_zero),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                  alu_src, alu_op, ext_zero, reg_dst, mem_to_reg, reg_write,
                  illegal, fault};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: compare at the falling edge, then move past the rising edge.
    task automatic step(input outs_t e, input string tag);
        @(negedge clk);
        check(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000: return K_R;
            6'b001000: return K_ADDI;
            6'b001100: return K_ANDI;
            6'b001101: return K_ORI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            default:   return K_BAD;
        endcase
    endfunction

    // zmode: 0/1 forces alu_zero in EXEC, 2 randomizes it.
    task automatic run_instr(input logic [5:0] op, input int fd, input int md, input int zmode);
        outs_t e;
        int    k;
        logic  ext;
        logic  z;
        string nm;
        k   = kind_of(op);
        ext = op[3] & op[2];
        nm  = $sformatf("op%b", op);

        instr = {op, 26'($urandom)};
        for (int i = 0; i < fd; i++) begin
            imem_ack = 1'b0;
            dmem_ack = 1'($urandom);
            e = '0; e.imem_req = 1'b1;
            step(e, {nm, "/fetch_wait"});
        end
        imem_ack = 1'b1;
        dmem_ack = 1'($urandom);
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(e, {nm, "/fetch_ack"});

        instr    = $urandom;
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        e = '0; e.ext_zero = ext; e.illegal = (k == K_BAD);
        step(e, {nm, "/decode"});
        if (k == K_BAD) return;

        z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
        alu_zero = z;
        e = '0;
        e.ext_zero = ext;
        e.alu_src  = (k == K_ADDI || k == K_ANDI || k == K_ORI || k == K_LW || k == K_SW);
        e.alu_op   = (k == K_R) ? 2'b10 :
                     (k == K_ANDI || k == K_ORI) ? 2'b11 :
                     (k == K_BEQ) ? 2'b01 : 2'b00;
        if (k == K_BEQ) begin e.pc_write = z;    e.pc_src = 2'b01; end
        if (k == K_J)   begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
        step(e, {nm, "/exec"});
        if (k == K_BEQ || k == K_J) return;
        alu_zero = 1'($urandom);

        if (k == K_LW || k == K_SW) begin
            e.dmem_req = 1'b1;
            e.dmem_we  = (k == K_SW);
            for (int i = 0; i < md; i++) begin
                dmem_ack = 1'b0;
                imem_ack = 1'($urandom);
                step(e, {nm, "/mem_wait"});
            end
            dmem_ack = 1'b1;
            imem_ack = 1'($urandom);
            step(e, {nm, "/mem_ack"});
            if (k == K_SW) return;
            e.dmem_req = 1'b0;
            e.dmem_we  = 1'b0;
        end

        dmem_ack     = 1'($urandom);
        imem_ack     = 1'($urandom);
        e.reg_write  = 1'b1;
        e.reg_dst    = (k == K_R);
        e.mem_to_reg = (k == K_LW);
        step(e, {nm, "/wb"});
    endtask

    logic [5:0] legal_ops [8];

    initial begin
        outs_t e;
        legal_ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                      6'b100011, 6'b101011, 6'b000100, 6'b000010};
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        instr    = '0;
        alu_zero = 1'b0;

        repeat (2) @(posedge clk);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        check("reset_outputs", obs, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step('0, "idle");

        run_instr(6'b001000, 0, 0, 2);
        run_instr(6'b001101, 0, 0, 2);
        run_instr(6'b100011, 0, 3, 2);
        run_instr(6'b101011, 1, 0, 2);
        run_instr(6'b000100, 0, 0, 1);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 2);
        run_instr(6'b000010, 2, 0, 2);
        run_instr(6'b000000, 0, 0, 2);
        run_instr(6'b001100, 0, 0, 2);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            int         r;
            r  = int'($urandom_range(0, 9));
            op = (r < 8) ? legal_ops[r] : 6'($urandom);
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
        end

        // Asynchronous reset in the middle of an instruction fetch.
        imem_ack = 1'b0;
        e = '0; e.imem_req = 1'b1;
        step(e, "pre_reset_fetch");
        @(negedge clk);
        check("pre_reset_req", obs, e);
        #1 reset = 1'b1;
        #1 check("reset_drop", obs, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        step('0, "idle_after_reset");
        run_instr(6'b001000, 0, 0, 2);

`ifdef MC_CTRL_TIMEOUT_EN
        imem_ack = 1'b0;
        e = '0; e.imem_req = 1'b1;
        for (int i = 0; i < 4; i++) step(e, "timeout_wait");
        e = '0; e.fault = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            step(e, "fault_sticky");
        end
        reset = 1'b1;
        @(negedge clk);
        check("fault_reset", obs, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        step('0, "idle_after_fault");
        run_instr(6'b100011, 0, 1, 2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
